block_mem_ctrl: RTL and testbench
=================================

Name: block_mem_ctrl

Overview:
- Parametrised successor to the fixed 8x8-bit memory controller: internal synchronous RAM plus sequencer that assembles or scatters whole cache blocks.
- Adds an explicit request/response handshake, configurable word width and block size, single-word writes and whole-block write-back.
- Sits between the cache controller and main memory: a cache miss issues a block read; dirty eviction issues a block write.

Parameters:
- ADDR_W, 16, word address width; RAM depth = 2**ADDR_W words.
- DATA_W, 8, bits per RAM word.
- BLK_WORDS, 8, words per block; power of two, 2..64; OFF_W = log2(BLK_WORDS).

Ports:
- clk  input  1  sole clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request (high only in IDLE).
- req_op  input  2  00 block read, 01 word write, 10 block write, 11 reserved.
- req_addr  input  ADDR_W  word address; block ops ignore the low OFF_W bits.
- req_wdata  input  DATA_W  word-write data.
- req_wblk  input  DATA_W*BLK_WORDS  block-write data; word k at [k*DATA_W +: DATA_W].
- blk_valid  output  1  read block available.
- blk_ready  input  1  consumer accepts the block.
- blk_data  output  DATA_W*BLK_WORDS  read block, same packing as req_wblk.
- busy  output  1  not IDLE.
- err  output  1  one-cycle pulse on acceptance of op 11.

Behaviour:
- Reset (async assert, sync release): state IDLE, req_ready=1, blk_valid=0, busy=0, err=0, blk_data=0, counters=0. RAM contents are not cleared and survive reset. An operation in flight is abandoned; a partial block write leaves earlier words written.
- Handshake: a request is accepted when req_valid & req_ready at a rising edge. At acceptance the controller registers req_op, base = {req_addr[ADDR_W-1:OFF_W], OFF_W'b0}, req_wdata and req_wblk. Inputs are don't-care after acceptance.
- States: IDLE, RD_ISSUE, RD_LAST, RD_HOLD, WR_BLK.
- IDLE:
  - Op 00 -> RD_ISSUE, cnt=0.
  - Op 01 writes req_wdata to req_addr on the accepting edge and stays in IDLE (zero-latency, back-to-back capable).
  - Op 10 -> WR_BLK, cnt=0.
  - Op 11: no RAM access, err=1 for the next cycle, stays in IDLE.
- RD_ISSUE: each cycle issues RAM read of base+cnt, cnt++. RAM has 1-cycle read latency; data for word k lands in blk_data slot k one cycle after issue. After issuing word BLK_WORDS-1 -> RD_LAST.
- RD_LAST: captures the final word -> RD_HOLD.
- RD_HOLD: blk_valid=1 and blk_data stable until blk_ready is sampled high, then -> IDLE with blk_valid=0.
  - Read latency: acceptance edge to blk_valid high = BLK_WORDS+2 edges (10 for defaults).
  - blk_ready high in the first RD_HOLD cycle completes the transfer in that cycle.
  - blk_data holds its last value after the handshake.
- WR_BLK: each cycle writes word cnt of the registered req_wblk to base+cnt, cnt++. After word BLK_WORDS-1 -> IDLE. Occupancy is BLK_WORDS cycles.
- Addressing: the offset counter is OFF_W bits wide; base+cnt never crosses the block boundary (no carry into the upper bits). Last block 0xFFF8..0xFFFF is valid; no wrap to 0.
- Read-after-write: a word write accepted in cycle n is visible to a block read accepted in cycle n+1.
- busy = (state != IDLE); req_ready = ~busy.

Test Plan:
- Preload 0x0000..0x0007 with 0x10..0x17 via op 01, then op 00 at addr 0x0005 -> blk_valid 10 edges after acceptance, blk_data=0x1716151413121110; req_ready low throughout.
- Op 10 at 0x1238 with req_wblk=0x8877665544332211, then op 00 at 0x123F -> busy for 8 cycles, read returns 0x8877665544332211; 0x1237 and 0x1240 remain unchanged.
- Block read with blk_ready held low for 5 cycles after blk_valid -> blk_valid and blk_data stable all 5 cycles; second request with req_valid held is accepted only after blk_ready, exactly one cycle later.
- Op 00 at 0xFFFF after preloading 0xFFF8..0xFFFF -> data from 0xFFF8..0xFFFF only, no access to 0x0000.
- Assert reset_n low mid-RD_ISSUE (cnt=3), release -> blk_valid=0 and req_ready=1 immediately; earlier written data still readable.
- Op 11 -> err pulses one cycle, no RAM change, req_ready stays 1; repeat with BLK_WORDS=4, DATA_W=16: block read latency 6 edges, 64-bit blk_data packs correctly.

Source files
------------

// File: rtl/block_mem_ctrl.sv
// Block memory controller: internal synchronous RAM with a request/response sequencer
// that gathers whole blocks on reads and scatters them on block write-back.
module block_mem_ctrl #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned BLK_WORDS = 8
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [1:0]                  req_op,
  input  logic [ADDR_W-1:0]           req_addr,
  input  logic [DATA_W-1:0]           req_wdata,
  input  logic [DATA_W*BLK_WORDS-1:0] req_wblk,
  output logic                        blk_valid,
  input  logic                        blk_ready,
  output logic [DATA_W*BLK_WORDS-1:0] blk_data,
  output logic                        busy,
  output logic                        err
);

  localparam int unsigned OFF_W = $clog2(BLK_WORDS);
  localparam int unsigned HI_W  = ADDR_W - OFF_W;
  localparam int unsigned BLK_W = DATA_W * BLK_WORDS;
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(BLK_WORDS - 1);

  localparam logic [1:0] OP_BLK_RD  = 2'b00;
  localparam logic [1:0] OP_WR_WORD = 2'b01;
  localparam logic [1:0] OP_BLK_WR  = 2'b10;
  localparam logic [1:0] OP_RSVD    = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StRdIssue,
    StRdLast,
    StRdHold,
    StWrBlk
  } state_e;

  state_e            state_q, state_d;
  logic [OFF_W-1:0]  cnt_q, cnt_d;
  logic [HI_W-1:0]   base_hi_q;
  logic [BLK_W-1:0]  wblk_q;
  logic [BLK_W-1:0]  blk_data_q;
  logic              err_q;
  logic              pend_q;
  logic [OFF_W-1:0]  slot_q;
  logic [DATA_W-1:0] rdata_q;

  logic              accept;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              rd_en;
  logic [ADDR_W-1:0] mem_raddr;

  logic [DATA_W-1:0] mem [DEPTH];

  assign accept    = req_valid & req_ready;
  assign req_ready = (state_q == StIdle);
  assign busy      = ~req_ready;
  assign blk_valid = (state_q == StRdHold);
  assign blk_data  = blk_data_q;
  assign err       = err_q;

  // Block ops concatenate the offset counter below the block base, so no carry can escape.
  assign rd_en     = (state_q == StRdIssue);
  assign mem_raddr = {base_hi_q, cnt_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          case (req_op)
            OP_BLK_RD: begin
              state_d = StRdIssue;
              cnt_d   = '0;
            end
            OP_BLK_WR: begin
              state_d = StWrBlk;
              cnt_d   = '0;
            end
            default: ;
          endcase
        end
      end
      StRdIssue: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_OFF) state_d = StRdLast;
      end
      StRdLast: state_d = StRdHold;
      StRdHold: begin
        if (blk_ready) state_d = StIdle;
      end
      StWrBlk: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_OFF) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = req_addr;
    mem_wdata = req_wdata;
    if (accept && (req_op == OP_WR_WORD)) begin
      mem_we = 1'b1;
    end else if (state_q == StWrBlk) begin
      mem_we    = 1'b1;
      mem_waddr = {base_hi_q, cnt_q};
      mem_wdata = wblk_q[cnt_q*DATA_W +: DATA_W];
    end
  end

  // RAM array and its read register are deliberately outside reset: contents survive reset_n.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (rd_en) rdata_q <= mem[mem_raddr];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      base_hi_q  <= '0;
      wblk_q     <= '0;
      blk_data_q <= '0;
      err_q      <= 1'b0;
      pend_q     <= 1'b0;
      slot_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= accept && (req_op == OP_RSVD);
      pend_q  <= rd_en;
      slot_q  <= cnt_q;
      if (accept) begin
        base_hi_q <= req_addr[ADDR_W-1:OFF_W];
        wblk_q    <= req_wblk;
      end
      // Word read one cycle earlier lands in its slot now.
      if (pend_q) blk_data_q[slot_q*DATA_W +: DATA_W] <= rdata_q;
    end
  end

endmodule

// File: tb/tb_block_mem_ctrl.sv
// Self-checking bench for block_mem_ctrl: default instance plus a 16-bit x 4-word instance,
// compared against a word-level associative-array memory model.
module tb_block_mem_ctrl;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic        v0, rdy0, bv0, br0, busy0, err0;
  logic [1:0]  op0;
  logic [15:0] a0;
  logic [7:0]  wd0;
  logic [63:0] wb0, bd0;

  logic        v1, rdy1, bv1, br1, busy1, err1;
  logic [1:0]  op1;
  logic [15:0] a1;
  logic [15:0] wd1;
  logic [63:0] wb1, bd1;

  int checks = 0;
  int errors = 0;

  logic [7:0] m0 [int unsigned];

  block_mem_ctrl u_dut0 (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (v0),
    .req_ready (rdy0),
    .req_op    (op0),
    .req_addr  (a0),
    .req_wdata (wd0),
    .req_wblk  (wb0),
    .blk_valid (bv0),
    .blk_ready (br0),
    .blk_data  (bd0),
    .busy      (busy0),
    .err       (err0)
  );

  block_mem_ctrl #(
    .ADDR_W    (16),
    .DATA_W    (16),
    .BLK_WORDS (4)
  ) u_dut1 (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (v1),
    .req_ready (rdy1),
    .req_op    (op1),
    .req_addr  (a1),
    .req_wdata (wd1),
    .req_wblk  (wb1),
    .blk_valid (bv1),
    .blk_ready (br1),
    .blk_data  (bd1),
    .busy      (busy1),
    .err       (err1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns one time unit after the accepting edge.
  task automatic req0(input logic [1:0] op, input int unsigned addr, input logic [7:0] wd,
                      input logic [63:0] wb);
    int n = 0;
    v0 = 1'b1; op0 = op; a0 = addr[15:0]; wd0 = wd; wb0 = wb;
    while (!rdy0 && n < 100) begin
      tick();
      n++;
    end
    if (n == 100) chk("req0_ready_timeout", 64'(rdy0), 64'd1);
    tick();
    v0 = 1'b0;
    if (op == 2'b01) begin
      m0[addr & 32'hFFFF] = wd;
    end else if (op == 2'b10) begin
      for (int k = 0; k < 8; k++) m0[(addr & 32'hFFF8) + k] = wb[k*8 +: 8];
    end
  endtask

  task automatic rd0(input string tag, input int unsigned addr, input int hold);
    logic [63:0] exp;
    logic [63:0] snap;
    int lat = 1;
    int bad = 0;
    int unsigned base = addr & 32'hFFF8;
    for (int k = 0; k < 8; k++) exp[k*8 +: 8] = m0.exists(base + k) ? m0[base + k] : 8'hxx;
    req0(2'b00, addr, 8'h00, 64'h0);
    // Latency counts the accepting edge as edge 1.
    while (!bv0 && lat < 50) begin
      if (rdy0 || !busy0) bad++;
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd10);
    chk({tag, "_busy_while_reading"}, 64'(bad), 64'd0);
    snap = bd0;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (!bv0 || (bd0 !== snap)) bad++;
    end
    if (hold > 0) chk({tag, "_hold_stable"}, 64'(bad), 64'd0);
    chk({tag, "_data"}, bd0, exp);
    br0 = 1'b1;
    tick();
    br0 = 1'b0;
    chk({tag, "_done_valid_ready"}, 64'({bv0, rdy0}), 64'b01);
    chk({tag, "_data_kept"}, bd0, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] exp1;
    int n;
    int bad;
    int unsigned base;

    reset_n = 1'b0;
    v0 = 0; br0 = 0; op0 = 0; a0 = 0; wd0 = 0; wb0 = 0;
    v1 = 0; br1 = 0; op1 = 0; a1 = 0; wd1 = 0; wb1 = 0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    chk("rst_flags0", 64'({rdy0, busy0, bv0, err0}), 64'b1000);
    chk("rst_data0", bd0, 64'h0);
    chk("rst_flags1", 64'({rdy1, busy1, bv1, err1}), 64'b1000);

    // Preload and read back; last write immediately precedes the read.
    for (int k = 0; k < 8; k++) req0(2'b01, k, 8'(8'h10 + k), 64'h0);
    rd0("preload_rd", 32'h0005, 0);
    chk("preload_const", bd0, 64'h1716151413121110);

    // Block write with known neighbours on both sides.
    req0(2'b10, 32'h1230, 8'h00, {$urandom, $urandom});
    req0(2'b10, 32'h1240, 8'h00, {$urandom, $urandom});
    req0(2'b10, 32'h1238, 8'h00, 64'h8877665544332211);
    n = 0;
    while (busy0 && n < 50) begin
      n++;
      tick();
    end
    chk("blkwr_busy_cycles", 64'(n), 64'd8);
    rd0("blkwr_rd", 32'h123F, 0);
    chk("blkwr_const", bd0, 64'h8877665544332211);
    rd0("blkwr_below", 32'h1237, 0);
    rd0("blkwr_above", 32'h1240, 0);

    // Consumer stalls; a held reserved request must wait for the handshake.
    rd0("stall_rd", 32'h0000, 5);
    req0(2'b00, 32'h1238, 8'h00, 64'h0);
    n = 0;
    while (!bv0 && n < 50) begin
      n++;
      tick();
    end
    v0 = 1'b1; op0 = 2'b11; a0 = 16'h0003; wd0 = 8'hEE;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (err0 || !bv0 || rdy0) bad++;
    end
    chk("held_req_blocked", 64'(bad), 64'd0);
    br0 = 1'b1;
    tick();
    br0 = 1'b0;
    chk("held_not_yet", 64'({err0, rdy0, bv0}), 64'b010);
    tick();
    v0 = 1'b0;
    chk("held_accept_err", 64'({err0, rdy0}), 64'b11);
    tick();
    chk("err_one_cycle", 64'(err0), 64'd0);
    rd0("rsvd_no_write", 32'h0000, 0);

    // Top-of-memory block, both word-filled and block-written.
    for (int k = 0; k < 8; k++) req0(2'b01, 32'hFFF8 + k, 8'(8'hC0 + k), 64'h0);
    rd0("top_rd", 32'hFFFF, 0);
    rd0("top_low_untouched", 32'h0000, 0);
    req0(2'b10, 32'hFFFC, 8'h00, {$urandom, $urandom});
    n = 0;
    while (busy0 && n < 50) begin
      n++;
      tick();
    end
    rd0("top_blkwr", 32'hFFF8, 0);
    rd0("top_blkwr_low", 32'h0007, 0);

    // Reset in the middle of a read issue sequence.
    req0(2'b00, 32'h0000, 8'h00, 64'h0);
    tick();
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    chk("midrst_flags", 64'({rdy0, busy0, bv0}), 64'b100);
    chk("midrst_data", bd0, 64'h0);
    #2;
    reset_n = 1'b1;
    tick();
    rd0("midrst_after", 32'h1238, 0);

    // Randomised block writes overlaid with word writes.
    for (int it = 0; it < 6; it++) begin
      base = $urandom_range(0, 8191) * 8;
      req0(2'b10, base, 8'h00, {$urandom, $urandom});
      n = 0;
      while (busy0 && n < 50) begin
        n++;
        tick();
      end
      for (int j = 0; j < 3; j++) req0(2'b01, base + $urandom_range(0, 7), 8'($urandom), 64'h0);
      rd0("rnd", base + $urandom_range(0, 7), $urandom_range(0, 3));
    end

    // 16-bit word, 4-word block instance.
    exp1 = {$urandom, $urandom};
    v1 = 1'b1; op1 = 2'b10; a1 = 16'h0041; wb1 = exp1;
    tick();
    v1 = 1'b0;
    n = 0;
    while (busy1 && n < 50) begin
      n++;
      tick();
    end
    chk("d1_wr_busy_cycles", 64'(n), 64'd4);
    v1 = 1'b1; op1 = 2'b01; a1 = 16'h0042; wd1 = 16'hBEEF;
    tick();
    exp1[2*16 +: 16] = 16'hBEEF;
    op1 = 2'b00; a1 = 16'h0043;
    tick();
    v1 = 1'b0;
    n = 1;
    while (!bv1 && n < 50) begin
      tick();
      n++;
    end
    chk("d1_latency", 64'(n), 64'd6);
    chk("d1_data", bd1, exp1);
    br1 = 1'b1;
    tick();
    br1 = 1'b0;
    chk("d1_done", 64'({bv1, rdy1}), 64'b01);
    v1 = 1'b1; op1 = 2'b11;
    tick();
    v1 = 1'b0;
    chk("d1_err_pulse", 64'({err1, rdy1}), 64'b11);
    tick();
    chk("d1_err_clear", 64'(err1), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
